// File: rtl/lfsr_scrambler_ctrl.sv
// Scrambler controller: reads pre_len/taps/seed from dat_mem, writes a PAD preamble and the message, both XORed with an LFSR.
// Optional macro LFSR_SEED_GUARD_EN replaces an all-zero seed with 1 and exposes the seed_fixed flag.
//
// state    | meaning
// IDLE     | waiting for go after reset
// RD_PRE   | read pre_len from CFG_BASE
// RD_TAPS  | read taps from CFG_BASE+1
// RD_SEED  | read seed from CFG_BASE+2
// LOAD     | load lfsr, pointers and down-counter
// PREAMBLE | write PAD ^ lfsr, pre_len cycles
// MESSAGE  | write message ^ lfsr, MSG_LEN cycles
// DONE     | run complete, go restarts
module lfsr_scrambler_ctrl #(
  parameter int             DW       = 8,
  parameter int             AW       = 8,
  parameter int             LW       = 6,
  parameter int             MSG_LEN  = 50,
  parameter int             MSG_BASE = 0,
  parameter int             CFG_BASE = 61,
  parameter int             OUT_BASE = 64,
  parameter logic [DW-1:0]  PAD      = 8'h5F
) (
  input  logic          clk,
  input  logic          init_n,
  input  logic          go,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] data_out,
  output logic          write_en,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] data_in,
  output logic [LW-1:0] lfsr
`ifdef LFSR_SEED_GUARD_EN
  ,
  output logic          seed_fixed
`endif
);

  localparam int             CW       = (AW > 8) ? AW : 8;
  localparam logic [CW-1:0]  MSG_LAST = CW'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, RD_PRE, RD_TAPS, RD_SEED, LOAD, PREAMBLE, MESSAGE, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    pre_len;
  logic [LW-1:0] taps, seed, seed_load, lfsr_step;
  logic [CW-1:0] cnt;
  logic [AW-1:0] rptr, wptr;

  assign lfsr_step = {lfsr[LW-2:0], ^(lfsr & taps)};

`ifdef LFSR_SEED_GUARD_EN
  assign seed_load = (seed == '0) ? LW'(1) : seed;

  always_ff @(posedge clk) begin
    if (!init_n || state == RD_PRE)
      seed_fixed <= 1'b0;
    else if (state == LOAD && seed == '0)
      seed_fixed <= 1'b1;
  end
`else
  assign seed_load = seed;
`endif

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state   <= IDLE;
      pre_len <= '0;
      taps    <= '0;
      seed    <= '0;
      lfsr    <= '0;
      cnt     <= '0;
      rptr    <= '0;
      wptr    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        RD_PRE:  pre_len <= data_out[7:0];
        RD_TAPS: taps    <= data_out[LW-1:0];
        RD_SEED: seed    <= data_out[LW-1:0];
        LOAD: begin
          lfsr <= seed_load;
          wptr <= AW'(OUT_BASE);
          rptr <= AW'(MSG_BASE);
          cnt  <= (pre_len == 8'd0) ? MSG_LAST : CW'(pre_len) - CW'(1);
        end
        PREAMBLE, MESSAGE: begin
          // one LFSR step and one pointer step per written byte
          lfsr <= lfsr_step;
          wptr <= wptr + AW'(1);
          if (state == MESSAGE)
            rptr <= rptr + AW'(1);
          cnt <= (cnt == '0) ? MSG_LAST : cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    raddr     = '0;
    write_en  = 1'b0;
    waddr     = '0;
    data_in   = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (go) state_nxt = RD_PRE;
      end
      RD_PRE: begin
        raddr     = AW'(CFG_BASE);
        state_nxt = RD_TAPS;
      end
      RD_TAPS: begin
        raddr     = AW'(CFG_BASE + 1);
        state_nxt = RD_SEED;
      end
      RD_SEED: begin
        raddr     = AW'(CFG_BASE + 2);
        state_nxt = LOAD;
      end
      LOAD: state_nxt = (pre_len == 8'd0) ? MESSAGE : PREAMBLE;
      PREAMBLE: begin
        write_en = 1'b1;
        waddr    = wptr;
        data_in  = PAD ^ DW'(lfsr);
        if (cnt == '0) state_nxt = MESSAGE;
      end
      MESSAGE: begin
        raddr    = rptr;
        write_en = 1'b1;
        waddr    = wptr;
        data_in  = data_out ^ DW'(lfsr);
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (go) state_nxt = RD_PRE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
